// File: rtl/pe_mac_pipe.sv
// Pipelined signed/unsigned WIDTH x WIDTH multiply-accumulate for the NPU PE.
// Input register, adder-tree level 1, product register, then the accumulate/output register; one stall net freezes all of them.
module pe_mac_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               signed_mode,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p_out,
  output logic [ACC_W-1:0]   acc_out,
  output logic               ovf
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned HALF = WIDTH / 2;

  logic stall_c;

  // S1 input register
  logic             s0_valid, s0_signed, s0_en, s0_clr;
  logic [WIDTH-1:0] s0_a, s0_b;

  // S1 first adder-tree level
  logic             s1_valid, s1_signed, s1_en, s1_clr;
  logic [PW-1:0]    s1_lvl [HALF];
  logic [PW-1:0]    lvl1_c [HALF];

  // S2 full product
  logic             s2_valid, s2_signed, s2_en, s2_clr;
  logic [PW-1:0]    s2_prod;
  logic [PW-1:0]    prod_c;

  // S3 accumulate
  logic [ACC_W-1:0] ext_c, base_c, addend_c, acc_next_c;
  logic [ACC_W:0]   sum_c;
  logic             ovf_new_c;

  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;

  // Sign-extended rows; the top row carries negative weight in signed mode.
  always_comb begin : pp_level1
    logic [PW-1:0] a_ext;
    logic [PW-1:0] pp [WIDTH];
    a_ext = {PW{s0_signed & s0_a[WIDTH-1]}};
    a_ext[WIDTH-1:0] = s0_a;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pp[i] = s0_b[i] ? (a_ext << i) : '0;
    end
    if (s0_signed) begin
      pp[WIDTH-1] = '0 - pp[WIDTH-1];
    end
    for (int j = 0; j < int'(HALF); j++) begin
      lvl1_c[j] = pp[2*j] + pp[2*j+1];
    end
  end

  // Remaining balanced adder-tree levels, reduced in place.
  always_comb begin : tree_rest
    logic [PW-1:0] t [HALF];
    for (int j = 0; j < int'(HALF); j++) begin
      t[j] = s1_lvl[j];
    end
    for (int s = 1; s < int'(HALF); s = s * 2) begin
      for (int j = 0; j + s < int'(HALF); j = j + 2 * s) begin
        t[j] = t[j] + t[j+s];
      end
    end
    prod_c = t[0];
  end

  // Accumulator next value and overflow of this transaction.
  always_comb begin : acc_calc
    ext_c = {ACC_W{s2_signed & s2_prod[PW-1]}};
    ext_c[PW-1:0] = s2_prod;
    base_c     = s2_clr ? '0 : acc_out;
    addend_c   = s2_en ? ext_c : '0;
    sum_c      = {1'b0, base_c} + {1'b0, addend_c};
    acc_next_c = sum_c[ACC_W-1:0];
    ovf_new_c  = 1'b0;
    if (s2_en) begin
      if (s2_signed) begin
        ovf_new_c = (base_c[ACC_W-1] == ext_c[ACC_W-1]) &&
                    (acc_next_c[ACC_W-1] != base_c[ACC_W-1]);
      end else begin
        ovf_new_c = sum_c[ACC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_signed <= 1'b0;
      s0_en     <= 1'b0;
      s0_clr    <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
    end else if (!stall_c) begin
      s0_valid  <= in_valid;
      s0_signed <= signed_mode;
      s0_en     <= acc_en;
      s0_clr    <= acc_clr;
      s0_a      <= a_in;
      s0_b      <= b_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_en     <= 1'b0;
      s1_clr    <= 1'b0;
      for (int j = 0; j < int'(HALF); j++) begin
        s1_lvl[j] <= '0;
      end
    end else if (!stall_c) begin
      s1_valid  <= s0_valid;
      s1_signed <= s0_signed;
      s1_en     <= s0_en;
      s1_clr    <= s0_clr;
      for (int j = 0; j < int'(HALF); j++) begin
        s1_lvl[j] <= lvl1_c[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_signed <= 1'b0;
      s2_en     <= 1'b0;
      s2_clr    <= 1'b0;
      s2_prod   <= '0;
    end else if (!stall_c) begin
      s2_valid  <= s1_valid;
      s2_signed <= s1_signed;
      s2_en     <= s1_en;
      s2_clr    <= s1_clr;
      s2_prod   <= prod_c;
    end
  end

  // Output register; bubbles clear out_valid but leave results and accumulator alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p_out     <= '0;
      acc_out   <= '0;
      ovf       <= 1'b0;
    end else if (!stall_c) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        p_out   <= s2_prod;
        acc_out <= acc_next_c;
        ovf     <= s2_clr ? ovf_new_c : (ovf | ovf_new_c);
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed/table bench for pe_mac_pipe: a 32-bit accumulator unit and a 16-bit one share the stimulus.
module tb_pe_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, signed_mode, acc_en, acc_clr, out_ready;
  logic [7:0]  a_in, b_in;
  logic        in_ready, out_valid, ovf;
  logic [15:0] p_out;
  logic [31:0] acc_out;
  logic        in_ready16, out_valid16, ovf16;
  logic [15:0] p_out16, acc_out16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_mac_pipe #(.WIDTH(8), .ACC_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .signed_mode(signed_mode), .acc_en(acc_en),
    .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .acc_out(acc_out), .ovf(ovf)
  );

  pe_mac_pipe #(.WIDTH(8), .ACC_W(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a_in(a_in), .b_in(b_in), .signed_mode(signed_mode), .acc_en(acc_en),
    .acc_clr(acc_clr), .out_valid(out_valid16), .out_ready(out_ready),
    .p_out(p_out16), .acc_out(acc_out16), .ovf(ovf16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic        en;
    logic        clr;
    logic        c16;
    logic [15:0] p;
    logic [31:0] acc;
    logic        ov;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic sm, input logic en, input logic clr,
                              input logic c16, input logic [15:0] p,
                              input logic [31:0] acc, input logic ov);
    vec_t v;
    v.a = a; v.b = b; v.sm = sm; v.en = en; v.clr = clr; v.c16 = c16;
    v.p = p; v.acc = acc; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic sm, input logic en, input logic clr);
    in_valid = v; a_in = a; b_in = b; signed_mode = sm; acc_en = en; acc_clr = clr;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Stream the queued vectors back to back; vector c is due after edge c+3.
  task automatic run_vecs();
    int n;
    vec_t e;
    n = vq.size();
    out_ready = 1'b1;
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) drive(1'b1, vq[c].a, vq[c].b, vq[c].sm, vq[c].en, vq[c].clr);
      else       drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("out_valid", out_valid, (c >= 3));
      if (c >= 3) begin
        e = vq[c-3];
        chk("p_out", p_out, e.p);
        if (e.c16) begin
          chk("acc16", acc_out16, e.acc);
          chk("ovf16", ovf16, e.ov);
        end else begin
          chk("acc_out", acc_out, e.acc);
          chk("ovf", ovf, e.ov);
        end
      end
    end
    vq.delete();
  endtask

  initial begin
    int ra, rb, sent, got;
    logic [15:0] exq[$];
    logic [15:0] snap;

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p_out", p_out, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Unsigned/signed products and accumulate behaviour.
    vq.push_back(mk(8'hFF, 8'hFF, 0, 1, 1, 0, 16'hFE01, 32'h0000FE01, 0));
    vq.push_back(mk(8'h00, 8'hAD, 0, 0, 0, 0, 16'h0000, 32'h0000FE01, 0));
    vq.push_back(mk(8'h80, 8'h80, 1, 0, 0, 0, 16'h4000, 32'h0000FE01, 0));
    vq.push_back(mk(8'hFF, 8'h01, 1, 1, 1, 0, 16'hFFFF, 32'hFFFFFFFF, 0));
    vq.push_back(mk(8'h7F, 8'h80, 1, 0, 0, 0, 16'hC080, 32'hFFFFFFFF, 0));
    vq.push_back(mk(8'd3,  8'd4,  0, 1, 1, 0, 16'h000C, 32'd12, 0));
    vq.push_back(mk(8'd5,  8'd6,  0, 1, 0, 0, 16'h001E, 32'd42, 0));
    vq.push_back(mk(8'd7,  8'd7,  0, 0, 0, 0, 16'h0031, 32'd42, 0));
    vq.push_back(mk(8'd2,  8'd3,  0, 0, 1, 0, 16'h0006, 32'd0, 0));
    vq.push_back(mk(8'hFF, 8'hFF, 1, 1, 0, 0, 16'h0001, 32'd1, 0));
    vq.push_back(mk(8'd200, 8'd100, 0, 1, 0, 0, 16'h4E20, 32'h00004E21, 0));
    vq.push_back(mk(8'd100, 8'hFD, 1, 1, 0, 0, 16'hFED4, 32'h00004CF5, 0));
    run_vecs();

    // Ten random unsigned pairs at full throughput.
    for (int k = 0; k < 10; k++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      vq.push_back(mk(8'(ra), 8'(rb), 0, 0, 1, 0, 16'(ra * rb), 32'd0, 0));
    end
    run_vecs();

    // 16-bit accumulator: unsigned carry, stickiness, clear, signed overflow.
    vq.push_back(mk(8'hFF, 8'hFF, 0, 1, 1, 1, 16'hFE01, 32'h0000FE01, 0));
    vq.push_back(mk(8'hFF, 8'hFF, 0, 1, 0, 1, 16'hFE01, 32'h0000FC02, 1));
    vq.push_back(mk(8'd1,  8'd1,  0, 1, 0, 1, 16'h0001, 32'h0000FC03, 1));
    vq.push_back(mk(8'd0,  8'd0,  0, 0, 0, 1, 16'h0000, 32'h0000FC03, 1));
    vq.push_back(mk(8'd2,  8'd2,  0, 1, 1, 1, 16'h0004, 32'h00000004, 0));
    vq.push_back(mk(8'h7F, 8'h7F, 1, 1, 1, 1, 16'h3F01, 32'h00003F01, 0));
    vq.push_back(mk(8'h7F, 8'h7F, 1, 1, 0, 1, 16'h3F01, 32'h00007E02, 0));
    vq.push_back(mk(8'h7F, 8'h7F, 1, 1, 0, 1, 16'h3F01, 32'h0000BD03, 1));
    run_vecs();
    idle(4);

    // Backpressure: out_ready low for cycles 6..10 with a full pipe.
    sent = 0;
    got  = 0;
    snap = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      drive(sent < 8, 8'(sent + 1), 8'd3, 1'b0, 1'b0, 1'b1);
      #1;
      if (cyc == 6) begin
        snap = p_out;
        chk("bp_full", out_valid, 1);
      end
      if (cyc > 6 && cyc < 11) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid_hold", out_valid, 1);
        chk("bp_p_hold", p_out, snap);
      end
      if (in_valid && in_ready) begin
        exq.push_back(16'((sent + 1) * 3));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exq.size() == 0) chk("bp_extra", 1, 0);
        else begin
          chk("bp_order", p_out, exq.pop_front());
          got++;
        end
      end
      @(posedge clk); #1;
    end
    chk("bp_sent", sent, 8);
    chk("bp_got", got, 8);
    out_ready = 1'b1;

    // Asynchronous reset with two transactions still in flight.
    drive(1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b1); @(posedge clk); #1;
    drive(1'b1, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0); @(posedge clk); #1;
    drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b1, 1'b0); @(posedge clk); #1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0); @(posedge clk); #1;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_acc", acc_out, 81);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_p", p_out, 0);
    chk("arst_acc", acc_out, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", out_valid, 0);
    end
    drive(1'b1, 8'd6, 8'd7, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_lat", out_valid, (k == 3));
    end
    chk("post_rst_p", p_out, 42);
    chk("post_rst_acc", acc_out, 42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_mac_pipe.md
# pe_mac_pipe

Parametrised, pipelined multiply-accumulate unit for the NPU processing element; the next generation of the fixed 8×8 unsigned single-register multiplier. Takes WIDTH-bit operands with per-transaction signed/unsigned mode. Each result passes through a 3-stage partial-product adder-tree pipeline into an optional running accumulator. Valid/ready handshakes on both sides allow the PE array to stall the datapath without losing data.

## Interface
- WIDTH, 8, operand width in bits; must be a power of two, ≥4.
- ACC_W, 32, accumulator width; must be ≥ 2*WIDTH.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready.
- a_in  in  WIDTH  multiplicand.
- b_in  in  WIDTH  multiplier.
- signed_mode  in  1  1 = operands two's complement, 0 = unsigned; sampled with the transaction.
- acc_en  in  1  add this product into the accumulator.
- acc_clr  in  1  zero the accumulator before this transaction's add.
- out_valid  out  1  result present on outputs.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- p_out  out  2*WIDTH  product of the transaction.
- acc_out  out  ACC_W  accumulator value after this transaction.
- ovf  out  1  sticky accumulator overflow flag.

## Operation
- Stage S1: register a, b, signed_mode, acc_en, acc_clr, and valid. Form WIDTH partial products. In signed mode, use Baugh-Wooley or sign-extended rows so the 2*WIDTH result is exact two's complement. Register the first adder-tree level.
- Stage S2: complete the remaining adder-tree levels. Register the full 2*WIDTH product plus control.
- Stage S3 (output register): p_out ← product.
  - ext = sign-extend(product) if signed_mode, else zero-extend, to ACC_W.
  - base = acc_clr ? 0 : acc.
  - acc_next = base + (acc_en ? ext : 0), wrap-around modulo 2^ACC_W.
  - acc_out ← acc_next.
- Overflow:
  - Signed mode: set when base and ext have equal sign and acc_next's sign differs.
  - Unsigned mode: set on carry out of ACC_W.
  - Only evaluated when acc_en = 1.
  - ovf is sticky (OR with new). acc_clr reloads ovf with this transaction's overflow only.
- acc_en=0 with acc_clr=1: accumulator cleared to 0, ovf cleared, p_out still valid.
- Bubbles (valid=0) flow through stages and never modify acc_out or ovf.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - When stall, every stage register, acc_out, and ovf hold.
  - When !stall, all stages advance together.

## Timing
- Reset (rst_n low, asynchronous): all stage valids 0; out_valid=0, p_out=0, acc_out=0, ovf=0. in_ready=1 as soon as reset asserts.
- Reset mid-operation: in-flight transactions are discarded, no partial output. First accept after deassertion yields a normal result.
- Latency:
  - Transaction accepted at edge k gives out_valid=1 with its results after edge k+3, provided no stall occurs in between.
  - Each stall cycle adds one cycle of latency.
- Throughput: one transaction per cycle with out_ready held high. Results exit in acceptance order.
- Outputs (p_out, acc_out, ovf, out_valid) are stable while out_valid && !out_ready.
- Simultaneous output handshake and input accept in the same cycle is legal. in_ready depends on out_ready, so a consumer accepting this cycle unstalls the input side the same cycle.
- Accumulator updates at most once per transaction, at entry into S3, never during stall.

## Test plan
- Unsigned WIDTH=8:
  - 255×255 → p_out=0xFE01 three cycles after accept.
  - 0×173 → 0x0000.
  - Back-to-back stream of 10 random pairs → 10 consecutive out_valid cycles, all products correct.
- Signed WIDTH=8:
  - −128×−128 → 0x4000.
  - −1×1 → 0xFFFF.
  - 127×−128 → 0xC080.
  - With acc_clr+acc_en, acc_out = sign-extended value (0xFFFFFFFF for −1×1).
- Accumulate:
  - 3×4 with acc_clr=1, acc_en=1 → acc_out=12.
  - Then 5×6 with acc_en=1 → 42.
  - Then 7×7 with acc_en=0 → p_out=49, acc_out=42.
  - Then acc_clr=1, acc_en=0 → acc_out=0.
- Overflow, ACC_W=16 unsigned:
  - 255×255 twice with accumulate → acc_out=0xFC02, ovf=1.
  - Further non-overflowing adds keep ovf=1; acc_clr transaction clears it.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with a full pipeline → in_ready=0, outputs frozen.
  - Release → the 3 in-flight plus pending results appear in order with no loss or duplication.
- Reset: assert rst_n=0 asynchronously with 2 transactions in flight → all outputs 0 immediately, no out_valid after release until a new accept +3 cycles.
